// File: rtl/sc_seq_defs_pkg.sv
// rtl/sc_seq_defs_pkg.sv - shared state encodings and helpers for the upcounter sequencer
package sc_seq_defs;

   localparam logic [2:0] STATE_IDLE  = 3'd0;
   localparam logic [2:0] STATE_CLEAR = 3'd1;
   localparam logic [2:0] STATE_RUN   = 3'd2;
   localparam logic [2:0] STATE_PAUSE = 3'd3;
   localparam logic [2:0] STATE_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = STATE_IDLE,
      ST_CLEAR = STATE_CLEAR,
      ST_RUN   = STATE_RUN,
      ST_PAUSE = STATE_PAUSE,
      ST_DONE  = STATE_DONE
   } seq_state_e;

   function automatic logic state_is_busy(seq_state_e s);
      return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/sc_seq_prescaler.sv
// rtl/sc_seq_prescaler.sv - strobe-period prescaler with sync clear, enable and terminal match
module sc_seq_prescaler #(
   parameter int SEQ_PRESCWIDTH = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   input  logic [SEQ_PRESCWIDTH-1:0] period,
   output logic                      match
);

   logic [SEQ_PRESCWIDTH-1:0] cnt_q;
   logic [SEQ_PRESCWIDTH-1:0] cnt_d;

   assign match = (cnt_q == (period - SEQ_PRESCWIDTH'(1)));

   // Enabled count wraps to zero on the cycle it matches, which is the strobe cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = match ? '0 : cnt_q + SEQ_PRESCWIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sc_upcounter_sequencer.sv
// rtl/sc_upcounter_sequencer.sv - run controller issuing timed count strobes to an upcounter
module sc_upcounter_sequencer
   import sc_seq_defs::*;
#(
   parameter int SEQ_DATAWIDTH  = 8,
   parameter int SEQ_PRESCWIDTH = 20
) (
   input  logic                      SC_SEQ_CLOCK_50,
   input  logic                      SC_SEQ_RESET_InHigh,
   input  logic                      SC_SEQ_start_InLow,
   input  logic                      SC_SEQ_pause_InLow,
   input  logic [SEQ_PRESCWIDTH-1:0] SC_SEQ_period_InBUS,
   input  logic [SEQ_DATAWIDTH-1:0]  SC_SEQ_limit_InBUS,
   input  logic [SEQ_DATAWIDTH-1:0]  SC_SEQ_count_InBUS,
   output logic                      SC_SEQ_upcount_OutLow,
   output logic                      SC_SEQ_clear_OutHigh,
   output logic                      SC_SEQ_done_OutHigh,
   output logic                      SC_SEQ_busy_OutHigh
);

   seq_state_e                state_q, state_d;
   logic [SEQ_PRESCWIDTH-1:0] period_q, period_d;
   logic [SEQ_DATAWIDTH-1:0]  limit_q, limit_d;

   logic start_req;
   logic pause_req;
   logic at_limit;
   logic presc_clr;
   logic presc_en;
   logic presc_match;

   assign start_req = ~SC_SEQ_start_InLow;
   assign pause_req = ~SC_SEQ_pause_InLow;
   assign at_limit  = (SC_SEQ_count_InBUS >= limit_q);

   sc_seq_prescaler #(
      .SEQ_PRESCWIDTH(SEQ_PRESCWIDTH)
   ) u_prescaler (
      .clk    (SC_SEQ_CLOCK_50),
      .rst    (SC_SEQ_RESET_InHigh),
      .clr    (presc_clr),
      .en     (presc_en),
      .period (period_q),
      .match  (presc_match)
   );

   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      limit_d   = limit_q;
      presc_clr = 1'b0;
      presc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d  = ST_CLEAR;
               period_d = (SC_SEQ_period_InBUS == '0) ? SEQ_PRESCWIDTH'(1) : SC_SEQ_period_InBUS;
               limit_d  = SC_SEQ_limit_InBUS;
            end
         end
         ST_CLEAR: begin
            presc_clr = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // Restart outranks the terminal check so a caller can always re-arm.
            if (start_req) begin
               state_d  = ST_CLEAR;
               period_d = (SC_SEQ_period_InBUS == '0) ? SEQ_PRESCWIDTH'(1) : SC_SEQ_period_InBUS;
               limit_d  = SC_SEQ_limit_InBUS;
            end else if (at_limit) begin
               state_d = ST_DONE;
            end else if (pause_req) begin
               state_d = ST_PAUSE;
            end else begin
               presc_en = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (start_req) begin
               state_d  = ST_CLEAR;
               period_d = (SC_SEQ_period_InBUS == '0) ? SEQ_PRESCWIDTH'(1) : SC_SEQ_period_InBUS;
               limit_d  = SC_SEQ_limit_InBUS;
            end else if (!pause_req) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge SC_SEQ_CLOCK_50 or posedge SC_SEQ_RESET_InHigh) begin
      if (SC_SEQ_RESET_InHigh) begin
         state_q  <= ST_IDLE;
         period_q <= SEQ_PRESCWIDTH'(1);
         limit_q  <= '0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         limit_q  <= limit_d;
      end
   end

   // Strobe uses the live count feedback, so it stops the very cycle the limit is hit.
   assign SC_SEQ_upcount_OutLow = ~((state_q == ST_RUN) && !pause_req && presc_match && !at_limit);
   assign SC_SEQ_clear_OutHigh  = (state_q == ST_CLEAR);
   assign SC_SEQ_done_OutHigh   = (state_q == ST_DONE);
   assign SC_SEQ_busy_OutHigh   = state_is_busy(state_q);

endmodule

// File: tb/tb_sc_upcounter_sequencer.sv
// tb/tb_sc_upcounter_sequencer.sv - self-checking bench with upcounter and behavioural model
module tb_sc_upcounter_sequencer;

   localparam int DW = 8;
   localparam int PW = 20;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          start_n = 1'b1;
   logic          pause_n = 1'b1;
   logic [PW-1:0] period  = '0;
   logic [DW-1:0] limit   = '0;
   logic [DW-1:0] count_q;
   logic          up_n, clr, done, busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int up_q[$], done_q[$], clr_q[$], mup_q[$], mdone_q[$];

   // Behavioural model: run phase flags, a tick count of productive RUN cycles, and the count.
   bit m_clearing = 0, m_run = 0, m_paused = 0, m_donenow = 0;
   int m_ticks = 0, m_per = 1, m_lim = 0, m_cnt = 0;

   sc_upcounter_sequencer #(.SEQ_DATAWIDTH(DW), .SEQ_PRESCWIDTH(PW)) dut (
      .SC_SEQ_CLOCK_50       (clk),
      .SC_SEQ_RESET_InHigh   (rst),
      .SC_SEQ_start_InLow    (start_n),
      .SC_SEQ_pause_InLow    (pause_n),
      .SC_SEQ_period_InBUS   (period),
      .SC_SEQ_limit_InBUS    (limit),
      .SC_SEQ_count_InBUS    (count_q),
      .SC_SEQ_upcount_OutLow (up_n),
      .SC_SEQ_clear_OutHigh  (clr),
      .SC_SEQ_done_OutHigh   (done),
      .SC_SEQ_busy_OutHigh   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst)        count_q <= '0;
      else if (clr)   count_q <= '0;
      else if (!up_n) count_q <= count_q + 8'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int count_in(input int q[$], input int lo, input int hi);
      int n = 0;
      foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
      return n;
   endfunction

   function automatic int first_in(input int q[$], input int lo);
      foreach (q[i]) if (q[i] >= lo) return q[i];
      return -1;
   endfunction

   always @(negedge clk) begin : checker_b
      bit e_up, e_clr, e_done, e_busy, s, p;
      if (rst) begin
         m_clearing = 0; m_run = 0; m_paused = 0; m_donenow = 0;
         m_ticks = 0; m_per = 1; m_lim = 0; m_cnt = 0;
         e_up = 0; e_clr = 0; e_done = 0; e_busy = 0; s = 0; p = 0;
      end else begin
         s = !start_n;
         p = !pause_n;
         e_clr  = m_clearing;
         e_done = m_donenow;
         e_busy = m_clearing || m_run || m_paused;
         e_up   = m_run && !p && (m_cnt < m_lim) && ((m_ticks % m_per) == m_per - 1);
      end
      chk("upcount_n", 32'(up_n), 32'(!e_up));
      chk("clear", 32'(clr), 32'(e_clr));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("count", 32'(count_q), m_cnt);
      if (!up_n) up_q.push_back(cyc);
      if (done)  done_q.push_back(cyc);
      if (clr)   clr_q.push_back(cyc);
      if (e_up)  mup_q.push_back(cyc);
      if (e_done) mdone_q.push_back(cyc);
      if (!rst) begin
         if (m_donenow) begin
            m_donenow = 0;
         end else if (m_clearing) begin
            m_clearing = 0; m_run = 1; m_ticks = 0; m_cnt = 0;
         end else if (!(m_run || m_paused)) begin
            if (s) begin
               m_clearing = 1; m_per = (period == 0) ? 1 : int'(period); m_lim = int'(limit);
            end
         end else if (s) begin
            if (e_up) m_cnt++;
            m_run = 0; m_paused = 0; m_clearing = 1;
            m_per = (period == 0) ? 1 : int'(period); m_lim = int'(limit);
         end else if (m_run) begin
            if (m_cnt >= m_lim) begin
               m_run = 0; m_donenow = 1;
            end else if (p) begin
               m_run = 0; m_paused = 1;
            end else begin
               if (e_up) m_cnt++;
               m_ticks++;
            end
         end else if (!p) begin
            m_paused = 0; m_run = 1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int per, input int lim, output int t0);
      period  = PW'(per);
      limit   = DW'(lim);
      start_n = 1'b0;
      t0      = cyc;
      step(1);
      start_n = 1'b1;
   endtask

   task automatic wait_idle(input int maxc);
      int k = 0;
      while ((busy || done) && k < maxc) begin
         step(1);
         k++;
      end
      chk("wait_idle_in_budget", 32'(k < maxc), 32'd1);
      step(2);
   endtask

   task automatic run_s1(input string tag);
      int t0;
      pulse_start(4, 3, t0);
      wait_idle(200);
      chk({tag, "_clear_at"}, first_in(clr_q, t0) - t0, 1);
      chk({tag, "_strobes"}, count_in(up_q, t0, cyc), 3);
      chk({tag, "_model_strobes"}, count_in(mup_q, t0, cyc), 3);
      chk({tag, "_first_strobe"}, first_in(up_q, t0) - t0, 5);
      chk({tag, "_third_strobe"}, count_in(up_q, t0 + 13, t0 + 13), 1);
      chk({tag, "_done_at"}, first_in(done_q, t0) - t0, 15);
      chk({tag, "_model_done_at"}, first_in(mdone_q, t0) - t0, 15);
      chk({tag, "_count"}, 32'(count_q), 3);
      chk({tag, "_busy_after"}, 32'(busy), 0);
   endtask

   initial begin
      int t0, t1;
      #1;
      chk("rst_upcount_n", 32'(up_n), 1);
      chk("rst_clear", 32'(clr), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      step(2);
      rst = 1'b0;
      step(2);

      run_s1("s1");

      pulse_start(0, 5, t0);
      wait_idle(200);
      chk("s2_strobes", count_in(up_q, t0, cyc), 5);
      chk("s2_first_strobe", first_in(up_q, t0) - t0, 2);
      chk("s2_done_at", first_in(done_q, t0) - t0, 8);
      chk("s2_done_once", count_in(done_q, t0, cyc), 1);
      chk("s2_count", 32'(count_q), 5);

      pulse_start(7, 0, t0);
      wait_idle(200);
      chk("s3_strobes", count_in(up_q, t0, cyc), 0);
      chk("s3_done_at", first_in(done_q, t0) - t0, 3);
      chk("s3_count", 32'(count_q), 0);

      pulse_start(4, 3, t0);
      step(3);
      pause_n = 1'b0;
      step(9);
      pause_n = 1'b1;
      wait_idle(200);
      chk("s4_no_strobe_paused", count_in(up_q, t0 + 4, t0 + 14), 0);
      chk("s4_first_strobe", first_in(up_q, t0) - t0, 15);
      chk("s4_done_at", first_in(done_q, t0) - t0, 25);
      chk("s4_strobes", count_in(up_q, t0, cyc), 3);

      pulse_start(3, 8, t0);
      step(13);
      chk("s5_count_before", 32'(count_q), 4);
      period  = PW'(2);
      limit   = DW'(2);
      start_n = 1'b0;
      t1      = cyc;
      step(1);
      start_n = 1'b1;
      wait_idle(200);
      chk("s5_restart_clear", count_in(clr_q, t1, cyc), 1);
      chk("s5_post_strobes", count_in(up_q, t1 + 1, cyc), 2);
      chk("s5_strobe_a", first_in(up_q, t1 + 1) - t1, 3);
      chk("s5_strobe_b", count_in(up_q, t1 + 5, t1 + 5), 1);
      chk("s5_done_once", count_in(done_q, t0, cyc), 1);
      chk("s5_count", 32'(count_q), 2);

      pulse_start(4, 3, t0);
      step(5);
      #1 rst = 1'b1;
      #1;
      chk("s6_run_rst_busy", 32'(busy), 0);
      chk("s6_run_rst_upcount", 32'(up_n), 1);
      chk("s6_run_rst_count", 32'(count_q), 0);
      step(2);
      rst = 1'b0;
      step(1);
      pulse_start(4, 3, t0);
      step(3);
      pause_n = 1'b0;
      step(3);
      chk("s6_in_pause_busy", 32'(busy), 1);
      #1 rst = 1'b1;
      #1;
      chk("s6_pause_rst_busy", 32'(busy), 0);
      chk("s6_pause_rst_clear", 32'(clr), 0);
      pause_n = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      run_s1("s6_s1");

      for (int i = 0; i < 3000; i++) begin
         period  = PW'($urandom_range(0, 5));
         limit   = ($urandom_range(0, 7) == 0) ? 8'hFF : DW'($urandom_range(0, 10));
         start_n = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 9) == 0) pause_n = ~pause_n;
         rst = ($urandom_range(0, 599) == 0);
         step(1);
      end
      rst     = 1'b0;
      start_n = 1'b1;
      pause_n = 1'b1;
      wait_idle(2000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
